// File: rtl/trace_sequencer.sv
// trace_sequencer
// ---------------------------------------------------------------------------
// Frame-level controller for the column tracer.
//
// Once per frame, at hpos==0 of START_LINE (start of VBLANK), the sequencer
// spends one cycle copying the pending vector set into the active vectors.
// It then raises the tracer enable for the whole trace. The window closes
// when the tracer stores column LAST_COL. If VBLANK ends first
// (vpos==0 && hpos==0), the window is force-closed and a sticky overrun flag
// is raised. The active vectors only change in the latch cycle, so the
// tracer sees stable vectors for the full enable window.
//
// Optional feature (macro TRACE_SEQ_CYCLE_COUNT_EN):
//   defined   : a saturating 16-bit cycle counter measures the RUN phase.
//               trace_cycles holds the length of the last completed trace.
//   undefined : no counter and no register are built; trace_cycles reads 0.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   hpos, vpos                  VGA raster counters
//   vec_update                  strobe: capture the six *_in vectors as pending
//   playerX_in .. vplaneY_in    host-supplied vectors
//   tr_store, tr_column         tracer store strobe and column
//   overrun_clr                 clears the sticky overrun flag
//   tr_enable                   tracer enable window
//   playerX .. vplaneY          active vectors driven to the tracer
//   frame_count                 11-bit frame counter (tracer debug_frame)
//   busy                        high during the latch cycle and the trace
//   overrun                     sticky: a trace was aborted by end of VBLANK
//   trace_cycles                cycle count of the last completed trace
// ---------------------------------------------------------------------------
module trace_sequencer #(
    parameter int VEC_W      = 16,
    parameter int START_LINE = 480,
    parameter int LAST_COL   = 639
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             vec_update,
    input  logic [VEC_W-1:0] playerX_in,
    input  logic [VEC_W-1:0] playerY_in,
    input  logic [VEC_W-1:0] facingX_in,
    input  logic [VEC_W-1:0] facingY_in,
    input  logic [VEC_W-1:0] vplaneX_in,
    input  logic [VEC_W-1:0] vplaneY_in,
    input  logic             tr_store,
    input  logic [9:0]       tr_column,
    input  logic             overrun_clr,
    output logic             tr_enable,
    output logic [VEC_W-1:0] playerX,
    output logic [VEC_W-1:0] playerY,
    output logic [VEC_W-1:0] facingX,
    output logic [VEC_W-1:0] facingY,
    output logic [VEC_W-1:0] vplaneX,
    output logic [VEC_W-1:0] vplaneY,
    output logic [10:0]      frame_count,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      trace_cycles
);

    localparam logic [9:0] START_LINE_V = 10'(START_LINE);
    localparam logic [9:0] LAST_COL_V   = 10'(LAST_COL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t stateNext;

    // Raster and tracer events
    logic frameStart;
    logic vblankEnd;
    logic traceComplete;
    logic inLatch;
    logic inRun;
    logic abortNow;

    assign frameStart    = (vpos == START_LINE_V) && (hpos == 10'd0);
    assign vblankEnd     = (vpos == 10'd0) && (hpos == 10'd0);
    assign traceComplete = tr_store && (tr_column == LAST_COL_V);
    assign inLatch       = (state == LATCH);
    assign inRun         = (state == RUN);
    // Completion takes priority over the end-of-VBLANK abort.
    assign abortNow      = inRun && vblankEnd && !traceComplete;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and decoded outputs. The enable is decoded from the state
    // register, so it drops on the same edge that leaves RUN (completion,
    // abort or reset).
    always_comb begin
        stateNext = state;
        tr_enable = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (frameStart) begin
                    stateNext = LATCH;
                end
            end
            LATCH: begin
                // Enable stays low here so the tracer re-primes from the
                // freshly latched vectors.
                busy      = 1'b1;
                stateNext = RUN;
            end
            RUN: begin
                tr_enable = 1'b1;
                busy      = 1'b1;
                if (traceComplete) begin
                    stateNext = DONE;
                end else if (vblankEnd) begin
                    stateNext = IDLE;
                end
            end
            DONE: begin
                // Holding the enable low keeps the tracer primed, so it
                // cannot start a second pass in the same VBLANK.
                if (vblankEnd) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Vector sets, packed with playerX at index 0
    logic [5:0][VEC_W-1:0] vecIn;
    logic [5:0][VEC_W-1:0] vecPending;
    logic [5:0][VEC_W-1:0] vecActive;

    assign vecIn = {vplaneY_in, vplaneX_in, facingY_in, facingX_in,
                    playerY_in, playerX_in};

    // The host may overwrite the pending set at any time. Only the latch
    // cycle looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vecPending <= '0;
        end else if (vec_update) begin
            vecPending <= vecIn;
        end
    end

    // An update strobed in the latch cycle itself bypasses the pending
    // register, so the host can land vectors right up to the latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            vecActive <= '0;
        end else if (inLatch) begin
            vecActive <= vec_update ? vecIn : vecPending;
        end
    end

    assign playerX = vecActive[0];
    assign playerY = vecActive[1];
    assign facingX = vecActive[2];
    assign facingY = vecActive[3];
    assign vplaneX = vecActive[4];
    assign vplaneY = vecActive[5];

    // Frame counter: advances once per latched frame and wraps naturally
    // at 11 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (inLatch) begin
            frame_count <= frame_count + 11'd1;
        end
    end

    // Sticky overrun: an abort in the same cycle as a clear leaves it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (abortNow) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef TRACE_SEQ_CYCLE_COUNT_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cycleCount;
    logic        traceDoneNow;

    assign traceDoneNow = inRun && traceComplete;

    // cycleCount holds the number of RUN cycles already elapsed. A trace
    // that completes in its Nth RUN cycle therefore reports N.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
        end else if (inLatch) begin
            cycleCount <= '0;
        end else if (inRun) begin
            cycleCount <= satInc(cycleCount);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_cycles <= '0;
        end else if (traceDoneNow) begin
            trace_cycles <= satInc(cycleCount);
        end
    end
`else
    assign trace_cycles = '0;
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
// Bench for trace_sequencer: table of per-cycle vectors, directed multi-cycle
// sequences and randomized traffic, all compared against a frame-level model.
module tb_trace_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hpos, vpos;
    logic        vu;
    logic [15:0] vin [6];
    logic        store;
    logic [9:0]  col;
    logic        clr;

    logic        trEnable, busyO, overrunO;
    logic [15:0] outs [6];
    logic [10:0] frameO;
    logic [15:0] traceO;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trace_sequencer #(.VEC_W(16), .START_LINE(480), .LAST_COL(639)) dut (
        .clk(clk), .reset(rst), .hpos(hpos), .vpos(vpos), .vec_update(vu),
        .playerX_in(vin[0]), .playerY_in(vin[1]), .facingX_in(vin[2]),
        .facingY_in(vin[3]), .vplaneX_in(vin[4]), .vplaneY_in(vin[5]),
        .tr_store(store), .tr_column(col), .overrun_clr(clr),
        .tr_enable(trEnable),
        .playerX(outs[0]), .playerY(outs[1]), .facingX(outs[2]),
        .facingY(outs[3]), .vplaneX(outs[4]), .vplaneY(outs[5]),
        .frame_count(frameO), .busy(busyO), .overrun(overrunO),
        .trace_cycles(traceO)
    );

    // ---------------- frame-level reference model ----------------
    // Phases of a frame: waiting for VBLANK, the single copy cycle, the
    // enable window, and window-finished-waiting-for-end-of-VBLANK.
    localparam int PH_WAIT = 0, PH_COPY = 1, PH_TRACE = 2, PH_FINISHED = 3;
    int          mPhase;
    logic [15:0] mPend [6];
    logic [15:0] mAct  [6];
    int          mFrame, mCnt, mTrace;
    bit          mOv;

    task automatic modelReset();
        mPhase = PH_WAIT; mFrame = 0; mCnt = 0; mTrace = 0; mOv = 0;
        for (int i = 0; i < 6; i++) begin mPend[i] = 0; mAct[i] = 0; end
    endtask

    task automatic modelStep();
        bit fs, ve, cp, aborted;
        if (rst) begin modelReset(); return; end
        fs = (vpos == 480) && (hpos == 0);
        ve = (vpos == 0) && (hpos == 0);
        cp = store && (col == 639);
        aborted = 0;
        case (mPhase)
            PH_WAIT: if (fs) mPhase = PH_COPY;
            PH_COPY: begin
                for (int i = 0; i < 6; i++) mAct[i] = vu ? vin[i] : mPend[i];
                mFrame = (mFrame + 1) % 2048;
                mCnt = 0;
                mPhase = PH_TRACE;
            end
            PH_TRACE: begin
                if (cp) begin
                    mTrace = (mCnt + 1 > 65535) ? 65535 : mCnt + 1;
                    mPhase = PH_FINISHED;
                end else if (ve) begin
                    aborted = 1; mOv = 1; mPhase = PH_WAIT;
                end
                mCnt = (mCnt + 1 > 65535) ? 65535 : mCnt + 1;
            end
            default: if (ve) mPhase = PH_WAIT;
        endcase
        if (clr && !aborted) mOv = 0;
        if (vu) for (int i = 0; i < 6; i++) mPend[i] = vin[i];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compareModel(input string tag);
        int expTrace;
`ifdef TRACE_SEQ_CYCLE_COUNT_EN
        expTrace = mTrace;
`else
        expTrace = 0;
`endif
        chk({tag, ".tr_enable"}, 32'(trEnable), 32'(mPhase == PH_TRACE));
        chk({tag, ".busy"}, 32'(busyO), 32'(mPhase == PH_COPY || mPhase == PH_TRACE));
        chk({tag, ".frame"}, 32'(frameO), 32'(mFrame));
        chk({tag, ".overrun"}, 32'(overrunO), 32'(mOv));
        chk({tag, ".trace_cycles"}, 32'(traceO), 32'(expTrace));
        for (int i = 0; i < 6; i++) chk($sformatf("%s.vec%0d", tag, i), 32'(outs[i]), 32'(mAct[i]));
    endtask

    // One clock: inputs are already set; sample 1 time unit after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        modelStep();
        compareModel(tag);
    endtask

    task automatic setPos(input int v, input int h);
        vpos = 10'(v); hpos = 10'(h);
    endtask

    // ---------------- table of per-cycle vectors ----------------
    typedef struct {
        bit          r;
        int          vp, hp;
        bit          u;
        logic [15:0] pxIn;
        bit          st;
        int          c;
        bit          cl;
        bit          eEn, eBusy;
        int          eFrame;
        bit          eOv;
        logic [15:0] ePx;
    } row_t;

    row_t tbl [19];
    int guard;

    initial begin
        rst = 1; vu = 0; store = 0; col = 0; clr = 0;
        setPos(100, 5);
        for (int i = 0; i < 6; i++) vin[i] = 16'h1111 * 16'(i + 1);
        modelReset();

        // Reset state
        tick("rst0");
        tick("rst1");
        chk("reset.tr_enable", 32'(trEnable), 0);
        chk("reset.busy", 32'(busyO), 0);
        chk("reset.frame", 32'(frameO), 0);
        chk("reset.overrun", 32'(overrunO), 0);
        chk("reset.trace", 32'(traceO), 0);
        chk("reset.playerX", 32'(outs[0]), 0);
        for (int i = 0; i < 6; i++) vin[i] = 0;

        //          r  vpos hpos u  pxIn      st col  cl  en busy frm ov  px
        tbl[0]  = '{0, 100,  5, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 0, 16'h0000};
        tbl[1]  = '{0, 480,  0, 1, 16'h1234, 0,   0, 0, 0, 1, 0, 0, 16'h0000};
        tbl[2]  = '{0, 480,  1, 0, 16'h0000, 0,   0, 0, 1, 1, 1, 0, 16'h1234};
        tbl[3]  = '{0, 480,  2, 1, 16'h0A80, 0,   0, 0, 1, 1, 1, 0, 16'h1234};
        tbl[4]  = '{0, 500,  3, 0, 16'h0000, 0,   0, 0, 1, 1, 1, 0, 16'h1234};
        tbl[5]  = '{0,   0,  0, 0, 16'h0000, 0,   0, 0, 0, 0, 1, 1, 16'h1234};
        tbl[6]  = '{0, 100,  5, 0, 16'h0000, 0,   0, 1, 0, 0, 1, 0, 16'h1234};
        tbl[7]  = '{0, 480,  0, 0, 16'h0000, 0,   0, 0, 0, 1, 1, 0, 16'h1234};
        tbl[8]  = '{0, 480,  1, 0, 16'h0000, 0,   0, 0, 1, 1, 2, 0, 16'h0A80};
        tbl[9]  = '{0, 480,  2, 0, 16'h0000, 1, 639, 0, 0, 0, 2, 0, 16'h0A80};
        tbl[10] = '{0, 480,  0, 0, 16'h0000, 0,   0, 0, 0, 0, 2, 0, 16'h0A80};
        tbl[11] = '{0,   0,  0, 0, 16'h0000, 0,   0, 0, 0, 0, 2, 0, 16'h0A80};
        tbl[12] = '{0, 100,  3, 0, 16'h0000, 0,   0, 0, 0, 0, 2, 0, 16'h0A80};
        tbl[13] = '{0, 480,  0, 0, 16'h0000, 0,   0, 0, 0, 1, 2, 0, 16'h0A80};
        tbl[14] = '{0, 480,  1, 0, 16'h0000, 0,   0, 0, 1, 1, 3, 0, 16'h0A80};
        tbl[15] = '{0, 300,  7, 0, 16'h0000, 1, 638, 0, 1, 1, 3, 0, 16'h0A80};
        tbl[16] = '{0,   0,  0, 0, 16'h0000, 0,   0, 1, 0, 0, 3, 1, 16'h0A80};
        tbl[17] = '{0, 100,  5, 0, 16'h0000, 0,   0, 0, 0, 0, 3, 1, 16'h0A80};
        tbl[18] = '{0, 100,  5, 0, 16'h0000, 0,   0, 1, 0, 0, 3, 0, 16'h0A80};

        for (int r = 0; r < 19; r++) begin
            rst = tbl[r].r; setPos(tbl[r].vp, tbl[r].hp);
            vu = tbl[r].u; vin[0] = tbl[r].pxIn;
            store = tbl[r].st; col = 10'(tbl[r].c); clr = tbl[r].cl;
            tick($sformatf("row%0d", r));
            chk($sformatf("row%0d.en", r), 32'(trEnable), 32'(tbl[r].eEn));
            chk($sformatf("row%0d.busy", r), 32'(busyO), 32'(tbl[r].eBusy));
            chk($sformatf("row%0d.frame", r), 32'(frameO), 32'(tbl[r].eFrame));
            chk($sformatf("row%0d.ov", r), 32'(overrunO), 32'(tbl[r].eOv));
            chk($sformatf("row%0d.px", r), 32'(outs[0]), 32'(tbl[r].ePx));
        end
        vu = 0; store = 0; clr = 0; vin[0] = 0;

        // Long trace completing in its 10000th RUN cycle
        setPos(480, 0); tick("t3.start");
        setPos(480, 1); tick("t3.latch");
        setPos(490, 1);
        for (int i = 0; i < 9999; i++) tick("t3.run");
        store = 1; col = 10'd639; tick("t3.done");
        chk("t3.en", 32'(trEnable), 0);
        chk("t3.ov", 32'(overrunO), 0);
`ifdef TRACE_SEQ_CYCLE_COUNT_EN
        chk("t3.trace", 32'(traceO), 10000);
`else
        chk("t3.trace", 32'(traceO), 0);
`endif
        store = 0; setPos(480, 0); tick("t3.hold");
        chk("t3.hold_busy", 32'(busyO), 0);
        setPos(0, 0); tick("t3.idle");

        // Completion coinciding with end of VBLANK; update during latch cycle
        setPos(480, 0); tick("t5.start");
        vu = 1; vin[5] = 16'hFF00; setPos(480, 1); tick("t5.latch");
        chk("t5.vplaneY", 32'(outs[5]), 32'h0000FF00);
        vu = 0; vin[5] = 0; setPos(300, 9);
        for (int i = 0; i < 4; i++) tick("t5.run");
        store = 1; col = 10'd639; setPos(0, 0); tick("t5.both");
        chk("t5.ov", 32'(overrunO), 0);
        chk("t5.en", 32'(trEnable), 0);
`ifdef TRACE_SEQ_CYCLE_COUNT_EN
        chk("t5.trace", 32'(traceO), 5);
`else
        chk("t5.trace", 32'(traceO), 0);
`endif
        store = 0; tick("t5.exit");
        chk("t5.busy", 32'(busyO), 0);

        // Frame counter wrap
        guard = 0;
        while (mFrame != 2047 && guard < 3000) begin
            setPos(480, 0); tick("t6.s");
            setPos(480, 1); tick("t6.l");
            store = 1; col = 10'd639; setPos(480, 2); tick("t6.c");
            store = 0; setPos(0, 0); tick("t6.e");
            guard++;
        end
        chk("t6.reach2047", 32'(frameO), 2047);
        setPos(480, 0); tick("t6.ws");
        setPos(480, 1); tick("t6.wl");
        chk("t6.wrap", 32'(frameO), 0);
        chk("t6.run_en", 32'(trEnable), 1);

        // Reset in the middle of a trace, then a frame with no new update
        setPos(400, 4); rst = 1; tick("t6.rst");
        chk("t6.rst_en", 32'(trEnable), 0);
        chk("t6.rst_frame", 32'(frameO), 0);
        chk("t6.rst_busy", 32'(busyO), 0);
        rst = 0; for (int i = 0; i < 6; i++) vin[i] = 16'hBEEF;
        setPos(480, 0); tick("t6.ps");
        setPos(480, 1); tick("t6.pl");
        chk("t6.pend_cleared", 32'(outs[5]), 0);
        setPos(0, 0); tick("t6.abort");

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) setPos(480, 0);
            else if (sel == 1) setPos(0, 0);
            else setPos(int'($urandom_range(0, 524)), int'($urandom_range(1, 799)));
            rst = ($urandom_range(0, 299) == 0);
            vu = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 6; i++) vin[i] = 16'($urandom);
            store = ($urandom_range(0, 9) == 0);
            col = $urandom_range(0, 1) ? 10'd639 : 10'($urandom_range(0, 799));
            clr = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
